// File: rtl/darts_game_ctrl.sv
// darts_game_ctrl: two-player turn sequencer for the dart scoreboard.
// Define DARTS_DOUBLE_OUT_EN to require a double-ring dart for the winning throw.
module darts_game_ctrl #(
    parameter int unsigned START_PT       = 301,
    parameter int unsigned DARTS_PER_TURN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dart_come_i,
    input  logic [7:0] dart_position_x_i,
    input  logic [7:0] dart_position_y_i,
    output logic       score_req_o,
    output logic [7:0] score_x_o,
    output logic [7:0] score_y_o,
    input  logic       score_ack_i,
    input  logic [5:0] score_val_i,
    input  logic       score_dbl_i,
    output logic       game_set_o,
    output logic       player_1_done_o,
    output logic       player_2_done_o,
    output logic       player_1_win_o,
    output logic       player_2_win_o,
    output logic [8:0] player_1_pt_o,
    output logic [8:0] player_2_pt_o
);

    localparam logic [8:0] START_PT_9 = 9'(START_PT);
    localparam int         CNT_W      = $clog2(DARTS_PER_TURN + 1);
    localparam logic [CNT_W-1:0] TURN_DARTS = CNT_W'(DARTS_PER_TURN);

    typedef enum logic [2:0] {
        WAIT,
        REQ,
        UPD,
        GAP,
        OVER
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             active_p2;
    logic [CNT_W-1:0] dart_cnt;
    logic [8:0]       snap_pt;
    logic [5:0]       dart_val;
    logic             bust_q;
    logic [8:0]       pt_active;
    logic signed [9:0] rem;
    logic             upd_win;
    logic             upd_bust;
    logic [8:0]       pt_new;

`ifdef DARTS_DOUBLE_OUT_EN
    logic             dart_dbl;
`else
    logic             dbl_unused;
    assign dbl_unused = score_dbl_i;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    if (dart_come_i) state_nxt = REQ;
            REQ:     if (score_ack_i) state_nxt = UPD;
            UPD:     state_nxt = upd_win ? OVER : GAP;
            GAP:     state_nxt = WAIT;
            OVER:    state_nxt = OVER;
            default: state_nxt = WAIT;
        endcase
    end

    // Points arithmetic for the dart currently held in dart_val.
    always_comb begin
        pt_active = active_p2 ? player_2_pt_o : player_1_pt_o;
        rem       = $signed({1'b0, pt_active}) - $signed({4'b0000, dart_val});
`ifdef DARTS_DOUBLE_OUT_EN
        upd_win  = (rem == 10'sd0) && dart_dbl;
        upd_bust = (rem < 10'sd0) || (rem == 10'sd1) || ((rem == 10'sd0) && !dart_dbl);
`else
        upd_win  = (rem == 10'sd0);
        upd_bust = (rem < 10'sd0);
`endif
        if (upd_win) begin
            pt_new = 9'd0;
        end else if (upd_bust) begin
            pt_new = snap_pt;
        end else begin
            pt_new = rem[8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            score_req_o     <= 1'b0;
            score_x_o       <= 8'd0;
            score_y_o       <= 8'd0;
            game_set_o      <= 1'b0;
            player_1_done_o <= 1'b0;
            player_2_done_o <= 1'b0;
            player_1_win_o  <= 1'b0;
            player_2_win_o  <= 1'b0;
            player_1_pt_o   <= START_PT_9;
            player_2_pt_o   <= START_PT_9;
            snap_pt         <= START_PT_9;
            active_p2       <= 1'b0;
            dart_cnt        <= '0;
            dart_val        <= 6'd0;
            bust_q          <= 1'b0;
`ifdef DARTS_DOUBLE_OUT_EN
            dart_dbl        <= 1'b0;
`endif
        end else begin
            player_1_done_o <= 1'b0;
            player_2_done_o <= 1'b0;
            case (state)
                WAIT: begin
                    if (dart_come_i) begin
                        score_x_o   <= dart_position_x_i;
                        score_y_o   <= dart_position_y_i;
                        score_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (score_ack_i) begin
                        score_req_o <= 1'b0;
                        dart_val    <= (score_val_i > 6'd60) ? 6'd0 : score_val_i;
`ifdef DARTS_DOUBLE_OUT_EN
                        dart_dbl    <= score_dbl_i;
`endif
                    end
                end
                UPD: begin
                    dart_cnt <= dart_cnt + CNT_W'(1);
                    bust_q   <= upd_bust;
                    if (active_p2) begin
                        player_2_pt_o   <= pt_new;
                        player_2_done_o <= 1'b1;
                        if (upd_win) player_2_win_o <= 1'b1;
                    end else begin
                        player_1_pt_o   <= pt_new;
                        player_1_done_o <= 1'b1;
                        if (upd_win) player_1_win_o <= 1'b1;
                    end
                    if (upd_win) game_set_o <= 1'b1;
                end
                GAP: begin
                    // Turn hand-over: the snapshot is what a later bust restores.
                    if (bust_q || (dart_cnt == TURN_DARTS)) begin
                        active_p2 <= !active_p2;
                        dart_cnt  <= '0;
                        snap_pt   <= active_p2 ? player_1_pt_o : player_2_pt_o;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_darts_game_ctrl.sv
// tb_darts_game_ctrl: scoreboard bench; a reference model queues each dart's expected
// outcome and a monitor compares it when the matching done pulse appears.
`timescale 1ns/1ps
module tb_darts_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dart_come_i;
    logic [7:0] dart_position_x_i;
    logic [7:0] dart_position_y_i;
    logic       score_req_o;
    logic [7:0] score_x_o;
    logic [7:0] score_y_o;
    logic       score_ack_i;
    logic [5:0] score_val_i;
    logic       score_dbl_i;
    logic       game_set_o;
    logic       player_1_done_o;
    logic       player_2_done_o;
    logic       player_1_win_o;
    logic       player_2_win_o;
    logic [8:0] player_1_pt_o;
    logic [8:0] player_2_pt_o;

    always #5 clk = ~clk;

    darts_game_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .dart_come_i       (dart_come_i),
        .dart_position_x_i (dart_position_x_i),
        .dart_position_y_i (dart_position_y_i),
        .score_req_o       (score_req_o),
        .score_x_o         (score_x_o),
        .score_y_o         (score_y_o),
        .score_ack_i       (score_ack_i),
        .score_val_i       (score_val_i),
        .score_dbl_i       (score_dbl_i),
        .game_set_o        (game_set_o),
        .player_1_done_o   (player_1_done_o),
        .player_2_done_o   (player_2_done_o),
        .player_1_win_o    (player_1_win_o),
        .player_2_win_o    (player_2_win_o),
        .player_1_pt_o     (player_1_pt_o),
        .player_2_pt_o     (player_2_pt_o)
    );

    typedef struct {
        logic       p2;
        logic [8:0] p1_pt;
        logic [8:0] p2_pt;
        logic       win;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    int   m_pt[2];
    int   m_snap;
    int   m_act;
    int   m_cnt;
    bit   m_over;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pt[0] = 301;
        m_pt[1] = 301;
        m_snap  = 301;
        m_act   = 0;
        m_cnt   = 0;
        m_over  = 0;
    endtask

    task automatic model_dart(input int val, input bit dbl);
        int   v;
        int   rem;
        bit   win;
        bit   bust;
        bit   dbl_rule;
        exp_t e;
`ifdef DARTS_DOUBLE_OUT_EN
        dbl_rule = 1'b1;
`else
        dbl_rule = 1'b0;
`endif
        v    = (val > 60) ? 0 : val;
        rem  = m_pt[m_act] - v;
        win  = (rem == 0) && (dbl || !dbl_rule);
        bust = (rem < 0) || (dbl_rule && ((rem == 1) || ((rem == 0) && !dbl)));
        if (win) m_pt[m_act] = 0;
        else if (bust) m_pt[m_act] = m_snap;
        else m_pt[m_act] = rem;
        e.p2    = (m_act == 1);
        e.p1_pt = 9'(m_pt[0]);
        e.p2_pt = 9'(m_pt[1]);
        e.win   = win;
        sb_q.push_back(e);
        m_cnt++;
        if (win) begin
            m_over = 1;
        end else if (bust || (m_cnt == 3)) begin
            m_act  = 1 - m_act;
            m_cnt  = 0;
            m_snap = m_pt[m_act];
        end
    endtask

    // Called at a falling edge with the DUT in WAIT; returns at a falling edge back in WAIT.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [5:0] val,
                                 input logic dbl, input int delay);
        int req_cycles;
        req_cycles = 0;
        model_dart(int'(val), dbl);
        dart_come_i       = 1'b1;
        dart_position_x_i = x;
        dart_position_y_i = y;
        @(negedge clk);
        dart_come_i       = 1'b0;
        dart_position_x_i = ~x;
        dart_position_y_i = ~y;
        for (int k = 0; k < delay; k++) begin
            if (score_req_o) req_cycles++;
            checkOutput("req_x_hold", score_x_o, x);
            checkOutput("req_y_hold", score_y_o, y);
            @(negedge clk);
        end
        if (score_req_o) req_cycles++;
        checkOutput("req_x", score_x_o, x);
        checkOutput("req_y", score_y_o, y);
        score_ack_i = 1'b1;
        score_val_i = val;
        score_dbl_i = dbl;
        @(negedge clk);
        score_ack_i = 1'b0;
        score_val_i = 6'd0;
        score_dbl_i = 1'b0;
        checkOutput("req_cycles", req_cycles, delay + 1);
        checkOutput("req_drop", score_req_o, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (player_1_done_o || player_2_done_o) begin
            checkOutput("done_exclusive", player_1_done_o & player_2_done_o, 0);
            checkOutput("sb_has_entry", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                checkOutput("done_player2", player_2_done_o, mon_e.p2);
                checkOutput("p1_pt", player_1_pt_o, mon_e.p1_pt);
                checkOutput("p2_pt", player_2_pt_o, mon_e.p2_pt);
                checkOutput("win_flag", mon_e.p2 ? player_2_win_o : player_1_win_o, mon_e.win);
                checkOutput("game_set", game_set_o, mon_e.win);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int   dv[33] = '{20, 20, 20,  0, 63,  0, 60, 60, 60,  0,  0,  0,
                     11,  0,  0,  0,  0,  0, 40, 20,
                     60, 60, 60,  0,  0,  0, 60, 21,  0,  0,  0,  0, 40};

    initial begin
        reset             = 1'b0;
        dart_come_i       = 1'b0;
        dart_position_x_i = 8'd0;
        dart_position_y_i = 8'd0;
        score_ack_i       = 1'b0;
        score_val_i       = 6'd0;
        score_dbl_i       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checkOutput("rst_req", score_req_o, 0);
        checkOutput("rst_x", score_x_o, 0);
        checkOutput("rst_y", score_y_o, 0);
        checkOutput("rst_game_set", game_set_o, 0);
        checkOutput("rst_done", {player_1_done_o, player_2_done_o}, 0);
        checkOutput("rst_win", {player_1_win_o, player_2_win_o}, 0);
        checkOutput("rst_p1_pt", player_1_pt_o, 301);
        checkOutput("rst_p2_pt", player_2_pt_o, 301);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 33; i++) begin
            applyStimulus(8'(i * 3 + 1), 8'(255 - i), 6'(dv[i]), 1'b0,
                          (i == 12) ? 5 : ((i == 27) ? 2 : 0));
        end

        if (m_over) begin
            dart_come_i = 1'b1;
            repeat (6) begin
                @(negedge clk);
                checkOutput("over_no_req", score_req_o, 0);
                checkOutput("over_game_set", game_set_o, 1);
                checkOutput("over_p2_win", player_2_win_o, 1);
                checkOutput("over_p2_pt", player_2_pt_o, 0);
            end
            dart_come_i = 1'b0;
        end
        checkOutput("sb_drained", sb_q.size(), 0);

        // Restart, then abort a lookup in flight with reset.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        dart_come_i       = 1'b1;
        dart_position_x_i = 8'h5A;
        dart_position_y_i = 8'hA5;
        @(negedge clk);
        dart_come_i = 1'b0;
        checkOutput("mid_req_high", score_req_o, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("abort_req", score_req_o, 0);
        checkOutput("abort_p1_pt", player_1_pt_o, 301);
        checkOutput("abort_p2_pt", player_2_pt_o, 301);
        checkOutput("abort_game_set", game_set_o, 0);
        applyStimulus(8'h10, 8'h20, 6'd20, 1'b0, 0);
        checkOutput("sb_drained_end", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/darts_game_ctrl.md
# darts_game_ctrl

Turn-sequencing controller for the dart scoreboard. It accepts dart arrivals and fetches each dart's value from the position-to-score lookup over a request/acknowledge handshake. It applies each value to the active player's remaining points, enforces the three-darts-per-turn and bust rules, and detects the winner. It sits between the dart sensor front end and the scoreboard outputs that the system bench monitors.

## Interface

Parameters:
- START_PT, 301: remaining points per player at reset; must be ≤ 511.
- DARTS_PER_TURN, 3: darts per turn before play passes to the other player.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  one clock; reset is synchronous and active-low.
- dart_come_i  input  1  dart present; level-sampled in WAIT only.
- dart_position_x_i  input  8  dart x position; captured with dart_come_i.
- dart_position_y_i  input  8  dart y position; captured with dart_come_i.
- score_req_o  output  1  lookup request; held until acknowledged.
- score_x_o  output  8  captured x position; stable while score_req_o is high.
- score_y_o  output  8  captured y position; stable while score_req_o is high.
- score_ack_i  input  1  lookup result valid.
- score_val_i  input  6  dart value, 0..60; values above 60 are treated as 0.
- score_dbl_i  input  1  dart landed in a double ring; used only with DARTS_DOUBLE_OUT_EN.
- game_set_o  output  1  game over; a winner has been decided.
- player_1_done_o  output  1  one-cycle pulse per processed player-1 dart.
- player_2_done_o  output  1  one-cycle pulse per processed player-2 dart.
- player_1_win_o  output  1  player 1 won; sticky.
- player_2_win_o  output  1  player 2 won; sticky.
- player_1_pt_o  output  9  player 1 remaining points.
- player_2_pt_o  output  9  player 2 remaining points.

## Operation

State machine states: WAIT, REQ, UPD, GAP, OVER.

Reset (reset=0 at a clock edge):
- State goes to WAIT.
- Both points registers load START_PT; the turn-start snapshot loads START_PT.
- Active player is 1; dart count is 0.
- All 1-bit outputs are 0; score_x_o and score_y_o are 0.
- Reset asserted in any state, including mid-handshake, aborts the operation without any point update.

Transitions:
- WAIT: dart_come_i=1 captures x/y, goes to REQ.
- REQ: score_req_o=1. On score_ack_i=1, latch the value (and double flag), go to UPD.
- UPD:
  - Compute rem = pt_active − value, 10-bit signed.
  - rem > 0: pt_active ← rem.
  - rem = 0: win. pt_active ← 0, set the active player's win flag and game_set_o.
  - rem < 0: bust. pt_active ← turn-start snapshot; the turn ends.
  - Pulse the active player's done output; go to GAP, or to OVER on a win.
- GAP: one idle cycle, giving the driver time to present the next position.
  - Turn end (dart count = DARTS_PER_TURN, or bust): swap the active player, clear the dart count, snapshot the new player's points.
  - Go to WAIT.
- OVER: terminal. dart_come_i is ignored; outputs hold until reset.

Rules:
- dart_come_i held high across darts is legal. Each pass through WAIT consumes exactly one dart.
- dart_come_i outside WAIT is ignored and never queued.
- score_ack_i outside REQ is ignored.
- The dart count increments in UPD and is compared in GAP.

## Timing

- Latency from dart_come_i to request: dart_come_i sampled at edge N → score_req_o high from N+1.
- Ack to update: score_ack_i sampled at edge M → points, win and done registered at M+1. Points, win and done change together.
- done pulse: exactly one cycle, M+1 to M+2; never high for both players.
- Next dart: dart_come_i is sampled no earlier than edge M+3, after the GAP cycle.
- Zero-wait lookup: ack in the first REQ cycle gives a minimum of 4 cycles per dart.
- Request hold: score_req_o and score_x_o/score_y_o are held until ack; there is no timeout.
- Outputs: all outputs are registered; no combinational input-to-output path.

## Configuration

- DARTS_DOUBLE_OUT_EN defined: double-out rule.
  - rem = 0 with score_dbl_i=0 is a bust.
  - rem = 1 is a bust.
  - A win requires rem = 0 with score_dbl_i=1.
- DARTS_DOUBLE_OUT_EN undefined: score_dbl_i is ignored; any exact zero wins.

## Test plan

- Normal turn: START_PT=301; P1 darts 20, 20, 20 with zero-wait ack → player_1_pt_o 281, 261, 241. Three player_1_done_o pulses, then the next dart is charged to P2.
- Bust: P1 at 10 with turn-start snapshot 50; P1 dart 20 → player_1_pt_o=50, one done pulse, turn passes to P2 immediately.
- Win: P2 at 40; dart 40 → player_2_pt_o=0, player_2_win_o=1 and game_set_o=1 in the same cycle. Further darts produce no request and no done pulse.
- Slow lookup: ack delayed 5 cycles → score_req_o held 6 cycles, score_x_o/score_y_o constant. Update lands 1 cycle after ack.
- Double-out (macro on): P1 at 40; dart 40 with score_dbl_i=0 → bust with restore. With score_dbl_i=1 → win. With the macro off, both darts win.
- Reset mid-REQ: reset=0 while score_req_o=1 → next cycle score_req_o=0, both points=301, no done pulse, active player is 1.
